host_cmd_to_streams: RTL and testbench
======================================

// Module: host_cmd_to_streams
// PURPOSE
//  Command framer that sits directly upstream of the APB stream bridge.
//  It parses a host byte stream into framed burst commands: header, length, then payload.
//  It drives the bridge's address-latch input and its write stream.
//  It gates the bridge's read stream and returns read data, or a write ACK, on a host byte stream.
// PARAMETERS
//  ACK_EN   1   1: emit the header byte back to the host after a write burst; 0: no write response
// PORTS
//  CLK               in   1  clock; all logic on rising edge
//  RESETn            in   1  reset; synchronous, active-low
//  host_in_data      in   8  command/payload byte from host
//  host_in_valid     in   1  host byte valid
//  host_in_ready     out  1  host byte accepted when valid&ready
//  host_out_data     out  8  response byte to host
//  host_out_valid    out  1  response byte valid
//  host_out_ready    in   1  host accepts response byte
//  br_base_address   out  5  burst start address to bridge
//  br_latch_address  out  1  address-latch request to bridge
//  br_in_data        out  8  write byte to bridge
//  br_in_valid       out  1  write byte valid
//  br_in_ready       in   1  bridge accepts write byte; high only while bridge bus is idle
//  br_out_data       in   8  read byte from bridge
//  br_out_valid      in   1  read byte valid
//  br_out_ready      out  1  read request/consume; bridge starts a read when high and br_out_valid low
// BEHAVIOUR
//  Frame format
//   - byte0 = header: [7] 1=write, 0=read; [6:5] ignored; [4:0] start address.
//   - byte1 = LEN: burst length is LEN+1, range 1..256.
//   - Write frames carry LEN+1 payload bytes. Read frames have no payload.
//  Registers
//   - hdr[7:0]: captured on byte0 handshake.
//   - rem[8:0]: loaded with LEN+1 on byte1 handshake.
//   - br_base_address = hdr[4:0].
//  FSM states: HDR, LEN, LATCH, WDATA, RDATA, ACK. Reset state is HDR.
//   - HDR: host_in_ready=1. On handshake, capture hdr and go to LEN.
//   - LEN: host_in_ready=1. On handshake, load rem and go to LATCH.
//   - LATCH: br_latch_address=1 and host_in_ready=0.
//     When br_in_ready=1 (bridge idle, latch taken that cycle), go to WDATA if hdr[7]=1, else RDATA.
//   - WDATA: combinational pass-through.
//     br_in_data=host_in_data; br_in_valid=host_in_valid; host_in_ready=br_in_ready.
//     Each handshake decrements rem.
//     On the handshake with rem==1, go to ACK if ACK_EN=1, else HDR.
//   - RDATA: br_out_ready = host_out_ready & (rem!=0).
//     host_out_data=br_out_data; host_out_valid=br_out_valid.
//     Each br_out_valid&br_out_ready decrements rem. On that handshake with rem==1, go to HDR.
//     rem reaches 0 before br_out_valid next drops, so no extra read is ever started.
//   - ACK: host_out_data=hdr; host_out_valid=1. On host_out_ready, go to HDR.
//  Output defaults
//   - Outside the states above: br_in_valid=0, br_out_ready=0, br_latch_address=0, host_out_valid=0.
//   - host_out_data=0 when not valid.
//  Reset
//   - All outputs low except host_in_ready=1 (state HDR). hdr=0, rem=0.
//   - A reset mid-frame abandons the frame and returns to HDR. The bridge is reset by the same RESETn.
//  Latency
//   - No added latency on the data paths (combinational pass-through).
//   - LATCH costs at least 1 cycle, longer while the bridge is completing a prior access.
//  Boundaries
//   - LEN=0 gives exactly 1 data byte.
//   - LEN=255 gives 256 bytes; rem is 9 bits so it cannot overflow.
//   - Address wrap past 31 is done by the bridge (5-bit increment); this block does not track it.
//   - host_out_ready low in RDATA holds br_out_ready low. No new read starts; the pending byte is held by the bridge.
//   - host_in_valid low in WDATA stalls the burst indefinitely.
// TESTING
//  1 Write 0x83,0x02,11,22,33 (ACK_EN=1): latch addr 3; br_in gets 11,22,33; host_out gets 0x83; back in HDR.
//  2 Read 0x1F,0x01: latch addr 31; exactly 2 bridge reads; host gets 2 bytes. br_out_ready=0 the cycle after the 2nd pop.
//  3 Read LEN=0 with host_out_ready toggling 1/0 every cycle: exactly 1 read issued, byte delivered intact.
//  4 Write LEN=255 at addr 0: 256 bytes forwarded; rem 256->0; the next header is accepted immediately.
//  5 Back-to-back frames while the bridge is slow (PREADY low 5 cycles): LATCH holds until br_in_ready; no byte lost.
//  6 RESETn low for 1 cycle after 2 of 4 write bytes: state=HDR, host_in_ready=1, all other outputs 0; a new frame works.

Source files
------------

// File: rtl/host_cmd_to_streams.sv
// rtl/host_cmd_to_streams.sv - host byte-stream command framer feeding the APB stream bridge
module host_cmd_to_streams #(
    parameter logic ACK_EN = 1'b1
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic [7:0] host_in_data,
    input  logic       host_in_valid,
    output logic       host_in_ready,
    output logic [7:0] host_out_data,
    output logic       host_out_valid,
    input  logic       host_out_ready,
    output logic [4:0] br_base_address,
    output logic       br_latch_address,
    output logic [7:0] br_in_data,
    output logic       br_in_valid,
    input  logic       br_in_ready,
    input  logic [7:0] br_out_data,
    input  logic       br_out_valid,
    output logic       br_out_ready
);

    typedef enum logic [2:0] {
        ST_HDR,
        ST_LEN,
        ST_LATCH,
        ST_WDATA,
        ST_RDATA,
        ST_ACK
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] hdr;
    logic [8:0] rem;
    logic       in_hs;
    logic       wr_hs;
    logic       rd_hs;

    assign br_base_address = hdr[4:0];
    assign in_hs = host_in_valid & host_in_ready;
    assign wr_hs = (state == ST_WDATA) & host_in_valid & br_in_ready;
    assign rd_hs = (state == ST_RDATA) & br_out_valid & br_out_ready;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state <= ST_HDR;
            hdr   <= 8'h00;
            rem   <= 9'd0;
        end else begin
            state <= state_next;
            if (state == ST_HDR && in_hs) begin
                hdr <= host_in_data;
            end
            // rem is 9 bits so LEN=255 loads 256 without overflow
            if (state == ST_LEN && in_hs) begin
                rem <= {1'b0, host_in_data} + 9'd1;
            end else if (wr_hs || rd_hs) begin
                rem <= rem - 9'd1;
            end
        end
    end

    always_comb begin
        state_next       = state;
        host_in_ready    = 1'b0;
        host_out_data    = 8'h00;
        host_out_valid   = 1'b0;
        br_latch_address = 1'b0;
        br_in_data       = 8'h00;
        br_in_valid      = 1'b0;
        br_out_ready     = 1'b0;
        case (state)
            ST_HDR: begin
                host_in_ready = 1'b1;
                if (host_in_valid) begin
                    state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                host_in_ready = 1'b1;
                if (host_in_valid) begin
                    state_next = ST_LATCH;
                end
            end
            ST_LATCH: begin
                // bridge only takes the latch while idle, signalled by br_in_ready
                br_latch_address = 1'b1;
                if (br_in_ready) begin
                    state_next = hdr[7] ? ST_WDATA : ST_RDATA;
                end
            end
            ST_WDATA: begin
                br_in_data    = host_in_data;
                br_in_valid   = host_in_valid;
                host_in_ready = br_in_ready;
                if (wr_hs && rem == 9'd1) begin
                    state_next = ACK_EN ? ST_ACK : ST_HDR;
                end
            end
            ST_RDATA: begin
                // rem!=0 gating stops a surplus read after the last byte is popped
                br_out_ready   = host_out_ready & (rem != 9'd0);
                host_out_valid = br_out_valid;
                host_out_data  = br_out_valid ? br_out_data : 8'h00;
                if (rd_hs && rem == 9'd1) begin
                    state_next = ST_HDR;
                end
            end
            ST_ACK: begin
                host_out_data  = hdr;
                host_out_valid = 1'b1;
                if (host_out_ready) begin
                    state_next = ST_HDR;
                end
            end
            default: state_next = ST_HDR;
        endcase
    end

endmodule

// File: tb/tb_host_cmd_to_streams.sv
// tb/tb_host_cmd_to_streams.sv - frame-table bench with a behavioural bridge model
module tb_host_cmd_to_streams;

    logic       CLK;
    logic       RESETn;
    logic [7:0] host_in_data;
    logic       host_in_valid;
    logic       host_in_ready;
    logic [7:0] host_out_data;
    logic       host_out_valid;
    logic       host_out_ready;
    logic [4:0] br_base_address;
    logic       br_latch_address;
    logic [7:0] br_in_data;
    logic       br_in_valid;
    logic       br_in_ready;
    logic [7:0] br_out_data;
    logic       br_out_valid;
    logic       br_out_ready;

    host_cmd_to_streams #(.ACK_EN(1'b1)) dut (
        .CLK              (CLK),
        .RESETn           (RESETn),
        .host_in_data     (host_in_data),
        .host_in_valid    (host_in_valid),
        .host_in_ready    (host_in_ready),
        .host_out_data    (host_out_data),
        .host_out_valid   (host_out_valid),
        .host_out_ready   (host_out_ready),
        .br_base_address  (br_base_address),
        .br_latch_address (br_latch_address),
        .br_in_data       (br_in_data),
        .br_in_valid      (br_in_valid),
        .br_in_ready      (br_in_ready),
        .br_out_data      (br_out_data),
        .br_out_valid     (br_out_valid),
        .br_out_ready     (br_out_ready)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // bridge model: 2-cycle read latency, optional 5-cycle busy after each write
    logic [4:0]  baddr;
    int          busy;
    int          rd_cnt;
    int          reads;
    bit          slow;
    logic [7:0]  latch_q[$];
    logic [7:0]  win_q[$];
    logic [7:0]  hout_q[$];

    assign br_in_ready = (busy == 0) && (rd_cnt == 0) && !br_out_valid;

    always @(posedge CLK) begin
        if (host_out_valid && host_out_ready) hout_q.push_back(host_out_data);
        if (!RESETn) begin
            baddr        <= 5'd0;
            busy         <= 0;
            rd_cnt       <= 0;
            reads        <= 0;
            br_out_valid <= 1'b0;
            br_out_data  <= 8'h00;
        end else begin
            if (br_latch_address && br_in_ready) begin
                latch_q.push_back({3'b000, br_base_address});
                baddr <= br_base_address;
            end
            if (br_in_valid && br_in_ready) begin
                win_q.push_back(br_in_data);
                baddr <= baddr + 5'd1;
                if (slow) busy <= 5;
            end else if (busy > 0) begin
                busy <= busy - 1;
            end
            if (br_out_valid && br_out_ready) begin
                br_out_valid <= 1'b0;
            end else if (!br_out_valid && br_out_ready && rd_cnt == 0) begin
                reads  <= reads + 1;
                rd_cnt <= 2;
            end
            if (rd_cnt == 1) begin
                br_out_valid <= 1'b1;
                br_out_data  <= {3'b101, baddr};
                baddr        <= baddr + 5'd1;
                rd_cnt       <= 0;
            end else if (rd_cnt > 1) begin
                rd_cnt <= rd_cnt - 1;
            end
        end
    end

    int n_checks;
    int n_fail;
    int cyc;
    bit tog;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_out_ready();
        cyc++;
        host_out_ready = tog ? (cyc % 2 == 0) : 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit hs;
        hs = 1'b0;
        host_in_data  = b;
        host_in_valid = 1'b1;
        for (int k = 0; k < 2000 && !hs; k++) begin
            drive_out_ready();
            #4 hs = host_in_valid && host_in_ready;
            @(negedge CLK);
        end
        host_in_valid = 1'b0;
        host_in_data  = 8'h00;
        if (!hs) check("send_timeout", 0, 1);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_in_ready"}, int'(host_in_ready), 1);
        check({name, "_others"}, int'({host_out_data, host_out_valid, br_base_address,
              br_latch_address, br_in_data, br_in_valid, br_out_ready}), 0);
    endtask

    typedef struct {
        logic [7:0] hdr;
        logic [7:0] len;
        logic [7:0] seed;
        bit         toggle;
        bit         slow;
        logic [4:0] exp_addr;
        int         exp_wbytes;
        int         exp_reads;
        int         exp_outs;
    } vec_t;

    vec_t vecs[7];

    task automatic run_frame(input vec_t v);
        int wbase, obase, rbase, lbase, errs;
        bit done;
        wbase = win_q.size();
        obase = hout_q.size();
        lbase = latch_q.size();
        rbase = reads;
        tog   = v.toggle;
        slow  = v.slow;
        send_byte(v.hdr);
        send_byte(v.len);
        if (v.hdr[7]) begin
            for (int i = 0; i <= int'(v.len); i++) send_byte(v.seed + 8'(i * 17));
        end
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            if (hout_q.size() - obase >= v.exp_outs) done = 1'b1;
            else begin
                drive_out_ready();
                @(negedge CLK);
            end
        end
        check("frame_done", int'(done), 1);
        tog = 1'b0;
        host_out_ready = 1'b1;
        check("hdr_ready_after", int'(host_in_ready), 1);
        check("out_ready_after", int'(br_out_ready), 0);
        repeat (3) @(negedge CLK);
        check("latch_count", latch_q.size() - lbase, 1);
        if (latch_q.size() > lbase) check("latch_addr", int'(latch_q[lbase]), int'(v.exp_addr));
        check("wbyte_count", win_q.size() - wbase, v.exp_wbytes);
        check("read_count", reads - rbase, v.exp_reads);
        check("out_count", hout_q.size() - obase, v.exp_outs);
        errs = 0;
        for (int i = 0; i < v.exp_wbytes && wbase + i < win_q.size(); i++)
            if (win_q[wbase + i] !== v.seed + 8'(i * 17)) errs++;
        check("wbyte_data", errs, 0);
        errs = 0;
        for (int i = 0; i < v.exp_outs && obase + i < hout_q.size(); i++) begin
            if (v.hdr[7]) begin
                if (hout_q[obase + i] !== v.hdr) errs++;
            end else if (hout_q[obase + i] !== {3'b101, v.exp_addr + 5'(i)}) begin
                errs++;
            end
        end
        check("out_data", errs, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        tog = 1'b0;
        slow = 1'b0;
        RESETn = 1'b0;
        host_in_data = 8'h00;
        host_in_valid = 1'b0;
        host_out_ready = 1'b1;

        //            hdr    len    seed   tog  slow addr   wb  rd  out
        vecs[0] = '{8'h83, 8'h02, 8'h11, 1'b0, 1'b0, 5'd3,  3,   0, 1};
        vecs[1] = '{8'h1F, 8'h01, 8'h00, 1'b0, 1'b0, 5'd31, 0,   2, 2};
        vecs[2] = '{8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 5'd5,  0,   1, 1};
        vecs[3] = '{8'h80, 8'hFF, 8'h01, 1'b0, 1'b0, 5'd0,  256, 0, 1};
        vecs[4] = '{8'h8A, 8'h03, 8'h40, 1'b0, 1'b1, 5'd10, 4,   0, 1};
        vecs[5] = '{8'h0C, 8'h02, 8'h00, 1'b0, 1'b1, 5'd12, 0,   3, 3};
        vecs[6] = '{8'hE4, 8'h00, 8'h7E, 1'b0, 1'b0, 5'd4,  1,   0, 1};

        repeat (2) @(negedge CLK);
        check_idle_outputs("reset");
        RESETn = 1'b1;
        @(negedge CLK);

        foreach (vecs[i]) run_frame(vecs[i]);

        // reset after 2 of 4 write bytes abandons the frame
        slow = 1'b0;
        send_byte(8'h81);
        send_byte(8'h03);
        send_byte(8'hA1);
        send_byte(8'hA2);
        RESETn = 1'b0;
        @(negedge CLK);
        check_idle_outputs("midreset");
        RESETn = 1'b1;
        @(negedge CLK);
        check_idle_outputs("postreset");
        run_frame('{8'h82, 8'h01, 8'h33, 1'b0, 1'b0, 5'd2, 2, 0, 1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
